tile_row_scheduler: RTL

- Sequences the shared mandelbrot_engine so that tile results for the next macroblock row are computed ahead of display.
- Holds two row buffers of iteration counts in ping-pong: a front buffer read by the pixel path and a back buffer filled by the engine.
- Issues one tile request at a time over a start/done handshake, tags each result with its tile index, and swaps buffers at macroblock-row boundaries.
- Runs on the 50 MHz core clock; the colour mapper consumes rd_iter downstream.

---
 rtl/tile_row_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tile_row_scheduler.sv
// Schedules mandelbrot_engine tile requests one macroblock row ahead of display
// and keeps the results in a ping-pong pair of row buffers for the pixel path.
module tile_row_scheduler #(
  parameter int MAX_TILES_X = 20,
  parameter int ITER_W      = 6,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vblank_start,
  input  logic              row_advance,
  input  logic [3:0]        h_shift,
  input  logic [3:0]        v_shift,
  output logic              eng_start,
  output logic [9:0]        eng_px,
  output logic [9:0]        eng_py,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic [ITER_W-1:0] eng_iter,
  input  logic [4:0]        rd_x,
  output logic [ITER_W-1:0] rd_iter,
  output logic              row_ready,
  output logic              underrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FULL} state_t;

  state_t            state;
  logic [3:0]        h_sh;
  logic [3:0]        v_sh;
  logic [4:0]        tx;
  logic [4:0]        tag;
  logic [9:0]        ry;
  logic              front_sel;
  logic              discard;
  logic [ITER_W-1:0] buf0 [MAX_TILES_X];
  logic [ITER_W-1:0] buf1 [MAX_TILES_X];

  int                tiles_int;
  int                rows_int;
  logic [4:0]        tiles_per_row;
  logic [4:0]        last_tx;
  logic              done_ok;
  logic              last_done;
  logic              ready_eff;
  logic              ry_last;
  logic              in_flight;

  // Tile count is clamped to the buffer depth so the tag can never index past it.
  always_comb begin
    tiles_int = H_ACTIVE >> h_sh;
    if (tiles_int > MAX_TILES_X) tiles_int = MAX_TILES_X;
    if (tiles_int < 1) tiles_int = 1;
    rows_int      = (V_ACTIVE + (1 << v_sh) - 1) >> v_sh;
    tiles_per_row = 5'(tiles_int);
    last_tx       = 5'(tiles_int - 1);
    done_ok       = eng_done && !discard && (state == WAIT);
    last_done     = done_ok && (tag == last_tx);
    ready_eff     = row_ready || last_done;
    ry_last       = (int'(ry) + 1) >= rows_int;
    in_flight     = (state == WAIT) && !eng_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      h_sh      <= 4'd5;
      v_sh      <= 4'd3;
      tx        <= '0;
      tag       <= '0;
      ry        <= '0;
      front_sel <= 1'b0;
      discard   <= 1'b0;
      eng_start <= 1'b0;
      eng_px    <= '0;
      eng_py    <= '0;
      rd_iter   <= '0;
      row_ready <= 1'b0;
      underrun  <= 1'b0;
      for (int i = 0; i < MAX_TILES_X; i++) begin
        buf0[i] <= '0;
        buf1[i] <= '0;
      end
    end else begin
      eng_start <= 1'b0;

      // The write lands in the back buffer before any swap decided this cycle.
      if (done_ok) begin
        if (front_sel) buf0[tag] <= eng_iter;
        else           buf1[tag] <= eng_iter;
      end
      if (eng_done && discard) discard <= 1'b0;

      if (rd_x < tiles_per_row) rd_iter <= front_sel ? buf1[rd_x] : buf0[rd_x];
      else                      rd_iter <= '0;

      if (vblank_start) begin
        h_sh      <= h_shift;
        v_sh      <= v_shift;
        ry        <= '0;
        tx        <= '0;
        underrun  <= 1'b0;
        row_ready <= 1'b0;
        state     <= ISSUE;
        if (in_flight) discard <= 1'b1;
      end else if (row_advance && state != IDLE) begin
        front_sel <= ~front_sel;
        if (!ready_eff) underrun <= 1'b1;
        row_ready <= 1'b0;
        tx        <= '0;
        if (in_flight) discard <= 1'b1;
        if (!ry_last) begin
          ry    <= ry + 10'd1;
          state <= ISSUE;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          ISSUE: begin
            if (enable && !eng_busy && !discard) begin
              eng_start <= 1'b1;
              eng_px    <= {5'd0, tx} << h_sh;
              eng_py    <= ry << v_sh;
              tag       <= tx;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (done_ok) begin
              if (last_done) begin
                row_ready <= 1'b1;
                state     <= FULL;
              end else begin
                tx    <= tx + 5'd1;
                state <= ISSUE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
